// File: rtl/chip_test_sequencer.sv
// chip_test_sequencer: front-end controller for the DIP chip testers.
// A debounced Start press launches the selected tester, waits for its Done
// (or a timeout), latches the result onto the LEDs and releases the tester.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a debounced press with a valid Chip_sel
// S_LAUNCH  | Run pulse to the selected tester is high this cycle
// S_WAIT    | waiting for Done from the selected tester, timeout running
// S_SETTLE  | one cycle for the tester's registered RSLT to update
// S_CAPTURE | sample RSLT into the pass/fail LEDs and the pass counter
// S_RELEASE | DISP_RSLT pulse returns the tester to Halted
module chip_test_sequencer #(
    parameter int NUM_CHIPS       = 8,
    parameter int SEL_W           = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start_btn,
    input  logic [SEL_W-1:0]     Chip_sel,
    input  logic [NUM_CHIPS-1:0] Done_vec,
    input  logic [NUM_CHIPS-1:0] Rslt_vec,
    output logic [NUM_CHIPS-1:0] Run_vec,
    output logic                 DISP_RSLT,
    output logic                 Pass_led,
    output logic                 Fail_led,
    output logic                 Timeout_led,
    output logic                 Busy,
    output logic [SEL_W-1:0]     Last_chip,
    output logic [7:0]           Pass_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_SETTLE,
        S_CAPTURE,
        S_RELEASE
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Button path
    logic            sync1_q;
    logic            sync2_q;
    logic            db_level_q;
    logic            db_level_d;
    logic            db_prev_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            start_pulse;

    // Sequencer
    state_t               state_q;
    logic [SEL_W-1:0]     sel_q;
    logic [TO_W-1:0]      to_cnt_q;
    logic [NUM_CHIPS-1:0] run_q;
    logic                 disp_q;
    logic                 pass_q;
    logic                 fail_q;
    logic                 tmo_q;
    logic                 busy_q;
    logic [SEL_W-1:0]     last_q;
    logic [7:0]           pass_cnt_q;
    logic [7:0]           pass_cnt_d;
    logic                 sel_ok;

    // Debounce next-state: the level flips only after DEBOUNCE_CYCLES
    // consecutive mismatching samples; any matching sample restarts the count.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Two-flop synchronizer, debounce state and edge-detect history.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= Start_btn;
            sync2_q    <= sync1_q;
            db_level_q <= db_level_d;
            db_prev_q  <= db_level_q;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // Only the rising edge of the debounced level starts a test.
    assign start_pulse = db_level_q & ~db_prev_q;
    assign sel_ok      = int'({1'b0, Chip_sel}) < NUM_CHIPS;
    assign pass_cnt_d  = (pass_cnt_q == 8'hFF) ? pass_cnt_q : pass_cnt_q + 8'd1;

    // Sequencer FSM; every output is registered alongside the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            to_cnt_q   <= '0;
            run_q      <= '0;
            disp_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            tmo_q      <= 1'b0;
            busy_q     <= 1'b0;
            last_q     <= '0;
            pass_cnt_q <= '0;
        end else begin
            run_q  <= '0;
            disp_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_pulse && sel_ok) begin
                        sel_q   <= Chip_sel;
                        last_q  <= Chip_sel;
                        pass_q  <= 1'b0;
                        fail_q  <= 1'b0;
                        tmo_q   <= 1'b0;
                        run_q   <= NUM_CHIPS'(1) << Chip_sel;
                        busy_q  <= 1'b1;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    // Done wins over a timeout landing in the same cycle.
                    if (Done_vec[sel_q]) begin
                        state_q <= S_SETTLE;
                    end else if (to_cnt_q == TO_LAST) begin
                        tmo_q   <= 1'b1;
                        disp_q  <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    pass_q <= Rslt_vec[sel_q];
                    fail_q <= ~Rslt_vec[sel_q];
                    if (Rslt_vec[sel_q]) begin
                        pass_cnt_q <= pass_cnt_d;
                    end
                    disp_q  <= 1'b1;
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Run_vec     = run_q;
    assign DISP_RSLT   = disp_q;
    assign Pass_led    = pass_q;
    assign Fail_led    = fail_q;
    assign Timeout_led = tmo_q;
    assign Busy        = busy_q;
    assign Last_chip   = last_q;
    assign Pass_count  = pass_cnt_q;

endmodule
